// File: rtl/gb_video_pkg.sv
// Shared Game Boy video types, palette and default VGA 640x480@60 timing.
package gb_video_pkg;

    localparam int unsigned GB_W = 160;
    localparam int unsigned GB_H = 144;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    typedef logic [1:0] shade_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Raw video flags carried down the latency-matching delay line
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic win;
    } vflags_t;

    localparam rgb_t PALETTE [4] = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};
    localparam rgb_t BORDER_RGB  = 24'h000000;

endpackage

// File: rtl/vga_timing_gen.sv
// VGA pixel/line counters with raw (undelayed, active-high) sync and active flags.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] hc,
    output logic [9:0] vc,
    output logic       h_last_c,
    output logic       v_last_c,
    output logic       hsync_c,
    output logic       vsync_c,
    output logic       active_c
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    assign h_last_c = (hc == 10'(H_TOTAL - 1));
    assign v_last_c = (vc == 10'(V_TOTAL - 1));
    assign hsync_c  = (hc >= 10'(H_ACTIVE + H_FP)) && (hc < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_c  = (vc >= 10'(V_ACTIVE + V_FP)) && (vc < 10'(V_ACTIVE + V_FP + V_SYNC));
    assign active_c = (hc < 10'(H_ACTIVE)) && (vc < 10'(V_ACTIVE));

    // Advance column each pixel slot, line on column wrap, frame on line wrap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_en) begin
            if (h_last_c) begin
                hc <= '0;
                vc <= v_last_c ? 10'd0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

endmodule

// File: rtl/gb_vga_scanout.sv
// Scans the 160x144 frame buffer out as a 3x-scaled, centred window on 640x480 VGA.
module gb_vga_scanout
    import gb_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned SCALE    = 3,
    parameter int unsigned X_OFF    = 80,
    parameter int unsigned Y_OFF    = 24,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned FB_W     = GB_W,
    parameter int unsigned FB_H     = GB_H
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pix_en,
    input  logic [1:0] fb_pixel,
    output logic [8:0] X_read,
    output logic [8:0] Y_read,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       blank_n,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       frame_start
);

    localparam int unsigned X_END = X_OFF + SCALE * FB_W;
    localparam int unsigned Y_END = Y_OFF + SCALE * FB_H;
    localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

    logic [9:0]       hc;
    logic [9:0]       vc;
    logic             h_last_c;
    logic             v_last_c;
    logic             hsync_c;
    logic             vsync_c;
    logic             active_c;
    logic             win_x_c;
    logic             win_y_c;
    logic [SUB_W-1:0] xsub;
    logic [SUB_W-1:0] ysub;
    logic [8:0]       gbx;
    logic [8:0]       gby;
    vflags_t          dly [RD_LAT];
    vflags_t          tap_c;
    rgb_t             rgb_q;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clock    (clock),
        .reset_n  (reset_n),
        .pix_en   (pix_en),
        .hc       (hc),
        .vc       (vc),
        .h_last_c (h_last_c),
        .v_last_c (v_last_c),
        .hsync_c  (hsync_c),
        .vsync_c  (vsync_c),
        .active_c (active_c)
    );

    assign win_x_c = (hc >= 10'(X_OFF)) && (hc < 10'(X_END));
    assign win_y_c = (vc >= 10'(Y_OFF)) && (vc < 10'(Y_END));
    assign tap_c   = dly[RD_LAT-1];

    assign red   = rgb_q.r;
    assign green = rgb_q.g;
    assign blue  = rgb_q.b;

    // Divider-free scaling: sub-counters step the GB coordinate every SCALE pixels/lines
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xsub <= '0;
            gbx  <= '0;
            ysub <= '0;
            gby  <= '0;
        end else if (pix_en) begin
            if (hc == 10'(X_OFF - 1)) begin
                xsub <= '0;
                gbx  <= '0;
            end else if (win_x_c) begin
                if (xsub == SUB_W'(SCALE - 1)) begin
                    xsub <= '0;
                    if (gbx != 9'(FB_W - 1)) gbx <= gbx + 9'd1;
                end else begin
                    xsub <= xsub + SUB_W'(1);
                end
            end
            if (h_last_c) begin
                if (v_last_c || (vc == 10'(Y_OFF - 1))) begin
                    ysub <= '0;
                    gby  <= '0;
                end else if (win_y_c) begin
                    if (ysub == SUB_W'(SCALE - 1)) begin
                        ysub <= '0;
                        if (gby != 9'(FB_H - 1)) gby <= gby + 9'd1;
                    end else begin
                        ysub <= ysub + SUB_W'(1);
                    end
                end
            end
        end
    end

    // Present read coordinates; park out of range outside the window so the buffer can swap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            X_read <= 9'(FB_W);
            Y_read <= 9'(FB_H);
        end else if (pix_en) begin
            X_read <= (win_x_c && win_y_c) ? gbx : 9'(FB_W);
            Y_read <= (win_x_c && win_y_c) ? gby : 9'(FB_H);
        end
    end

    // Delay raw flags so they meet the returning pixel at the output register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(RD_LAT); i++) dly[i] <= '0;
        end else if (pix_en) begin
            dly[0] <= '{hsync: hsync_c, vsync: vsync_c, active: active_c,
                        win: win_x_c && win_y_c};
            for (int i = 1; i < int'(RD_LAT); i++) dly[i] <= dly[i-1];
        end
    end

    // Output stage: sync/blank and palette or border colour, all on the same slot
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            blank_n     <= 1'b0;
            rgb_q       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && h_last_c && v_last_c;
            if (pix_en) begin
                hsync_n <= ~tap_c.hsync;
                vsync_n <= ~tap_c.vsync;
                blank_n <= tap_c.active;
                if (!tap_c.active) begin
                    rgb_q <= '0;
                end else if (tap_c.win) begin
                    rgb_q <= PALETTE[fb_pixel];
                end else begin
                    rgb_q <= BORDER_RGB;
                end
            end
        end
    end

endmodule

// File: tb/tb_gb_vga_scanout.sv
// Directed bench: full-size scanout (RD_LAT 1 and 2) plus a shrunken-timing copy for frame-level checks.
module tb_gb_vga_scanout;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_b;
    logic pix_en;
    logic last_en;

    logic [1:0] fb_a, fb_c, fb_b;
    logic [1:0] ram_a, ram_c0, ram_c1, ram_b;
    logic [8:0] x_a, y_a, x_c, y_c, x_b, y_b;
    logic hs_a, vs_a, bl_a, fs_a;
    logic hs_c, vs_c, bl_c, fs_c;
    logic hs_b, vs_b, bl_b, fs_b;
    logic [7:0] r_a, g_a, b_a, r_c, g_c, b_c, r_b, g_b, b_b;
    logic [23:0] rgb_a, rgb_c, rgb_b;

    int n_checks = 0;
    int n_errors = 0;
    int slot_a = 0;
    int slot_b = 0;
    int viol_a = 0;
    int viol_b = 0;
    int fs_a_cnt = 0;
    int hs_low_b = 0;
    int vs_low_b = 0;
    int bl_high_b = 0;
    int pa, pb;

    always #10 clk = ~clk;

    assign rgb_a = {r_a, g_a, b_a};
    assign rgb_c = {r_c, g_c, b_c};
    assign rgb_b = {r_b, g_b, b_b};

    gb_vga_scanout #(.RD_LAT(1)) dut_a (
        .clock(clk), .reset_n(rst_n), .pix_en(pix_en), .fb_pixel(fb_a),
        .X_read(x_a), .Y_read(y_a), .hsync_n(hs_a), .vsync_n(vs_a), .blank_n(bl_a),
        .red(r_a), .green(g_a), .blue(b_a), .frame_start(fs_a));

    gb_vga_scanout #(.RD_LAT(2)) dut_c (
        .clock(clk), .reset_n(rst_n), .pix_en(pix_en), .fb_pixel(fb_c),
        .X_read(x_c), .Y_read(y_c), .hsync_n(hs_c), .vsync_n(vs_c), .blank_n(bl_c),
        .red(r_c), .green(g_c), .blue(b_c), .frame_start(fs_c));

    // 28x19 slots per frame, 4x3 image scaled 3x at (4,2)
    gb_vga_scanout #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(14), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .X_OFF(4), .Y_OFF(2), .RD_LAT(1), .FB_W(4), .FB_H(3)
    ) dut_b (
        .clock(clk), .reset_n(rst_b), .pix_en(pix_en), .fb_pixel(fb_b),
        .X_read(x_b), .Y_read(y_b), .hsync_n(hs_b), .vsync_n(vs_b), .blank_n(bl_b),
        .red(r_b), .green(g_b), .blue(b_b), .frame_start(fs_b));

    // Frame buffer models: one system clock to read, then RD_LAT-1 extra pixel-slot stages
    always @(posedge clk) begin
        ram_a  <= x_a[1:0];
        ram_c0 <= x_c[1:0];
        if (pix_en) ram_c1 <= ram_c0;
        ram_b  <= x_b[1:0];
        last_en <= pix_en;
    end
    assign fb_a = ram_a;
    assign fb_c = ram_c1;
    assign fb_b = ram_b;

    // Pixel-slot counters: value equals the DUT's hc/vc position since release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) slot_a <= 0;
        else if (pix_en) slot_a <= slot_a + 1;
    end
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) slot_b <= 0;
        else if (pix_en) slot_b <= slot_b + 1;
    end

    // pix_en high every second clock
    initial begin
        pix_en = 1'b0;
        forever begin
            @(posedge clk);
            #1 pix_en = ~pix_en;
        end
    end

    // Per-slot monitors: parking outside the window and first-frame sync/blank statistics
    always @(negedge clk) begin
        if (rst_n && fs_a) fs_a_cnt++;
        if (rst_n && last_en && slot_a >= 1) begin
            pa = slot_a - 1;
            if ((pa % 800) >= 640 && x_a < 9'd160 && y_a < 9'd144) viol_a++;
        end
        if (rst_b && last_en && slot_b >= 1) begin
            pb = (slot_b - 1) % 532;
            if (((pb % 28) >= 20 || (pb / 28) >= 11) && x_b < 9'd4 && y_b < 9'd3) viol_b++;
            if (slot_b >= 2 && slot_b <= 533) begin
                if (!hs_b) hs_low_b++;
                if (!vs_b) vs_low_b++;
                if (bl_b) bl_high_b++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_a(input int n);
        int guard;
        guard = 0;
        while (slot_a < n && guard < 200000) begin
            @(negedge clk);
            guard++;
        end
        if (slot_a != n) check("wait_a", 32'(slot_a), 32'(n));
    endtask

    task automatic wait_b(input int n);
        int guard;
        guard = 0;
        while (slot_b < n && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (slot_b != n) check("wait_b", 32'(slot_b), 32'(n));
    endtask

    task automatic wait_fs_b(input int exp_slot, input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!fs_b && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check(tag, 32'(slot_b), 32'(exp_slot));
        @(negedge clk);
        check({tag, "_width"}, 32'(fs_b), 32'd0);
    endtask

    // Full-size sequence; slot n shows X/Y for position n-1 and RGB/sync for n-1-RD_LAT
    task automatic seq_a();
        wait_a(641);   check("a_blank_h639", 32'(bl_a), 32'd1);
        wait_a(642);   check("a_blank_h640", 32'(bl_a), 32'd0);
                       check("a_rgb_hblank", 32'(rgb_a), 32'h000000);
        wait_a(657);   check("a_hs_h655", 32'(hs_a), 32'd1);
        wait_a(658);   check("a_hs_h656", 32'(hs_a), 32'd0);
        wait_a(753);   check("a_hs_h751", 32'(hs_a), 32'd0);
        wait_a(754);   check("a_hs_h752", 32'(hs_a), 32'd1);
        wait_a(18502); check("a_blank_v23", 32'(bl_a), 32'd1);
                       check("a_rgb_v23_border", 32'(rgb_a), 32'h000000);
        wait_a(19280); check("a_x_h79", 32'(x_a), 32'd160);
        wait_a(19281); check("a_x_h80", 32'(x_a), 32'd0);
                       check("a_y_v24", 32'(y_a), 32'd0);
                       check("c_x_h80", 32'(x_c), 32'd0);
                       check("a_rgb_h79", 32'(rgb_a), 32'h000000);
                       check("a_blank_h79", 32'(bl_a), 32'd1);
        wait_a(19282); check("a_rgb_h80", 32'(rgb_a), 32'hE0F8D0);
                       check("c_rgb_h79", 32'(rgb_c), 32'h000000);
        wait_a(19283); check("a_x_h82", 32'(x_a), 32'd0);
                       check("c_rgb_h80", 32'(rgb_c), 32'hE0F8D0);
        wait_a(19284); check("a_x_h83", 32'(x_a), 32'd1);
        wait_a(19285); check("a_rgb_h83", 32'(rgb_a), 32'h88C070);
        wait_a(19286); check("c_rgb_h83", 32'(rgb_c), 32'h88C070);
        wait_a(19288); check("a_rgb_h86", 32'(rgb_a), 32'h346856);
        wait_a(19291); check("a_rgb_h89", 32'(rgb_a), 32'h081820);
        wait_a(19760); check("a_x_h559", 32'(x_a), 32'd159);
        wait_a(19761); check("a_x_h560", 32'(x_a), 32'd160);
                       check("a_y_h560", 32'(y_a), 32'd144);
        wait_a(21101); check("a_y_v26", 32'(y_a), 32'd0);
        wait_a(21681); check("a_y_v27", 32'(y_a), 32'd1);
                       check("a_x_v27_h80", 32'(x_a), 32'd0);
        check("a_no_frame_start", 32'(fs_a_cnt), 32'd0);
        check("a_parked_hblank", 32'(viol_a), 32'd0);
    endtask

    // Shrunken-timing sequence: vertical scaling, frame timing, swap window, mid-frame reset
    task automatic seq_b();
        wait_b(61);  check("b_x_h4", 32'(x_b), 32'd0);
                     check("b_y_v2", 32'(y_b), 32'd0);
        wait_b(62);  check("b_rgb_h4", 32'(rgb_b), 32'hE0F8D0);
        wait_b(72);  check("b_x_h15", 32'(x_b), 32'd3);
        wait_b(73);  check("b_x_h16", 32'(x_b), 32'd4);
                     check("b_y_h16", 32'(y_b), 32'd3);
        wait_b(117); check("b_y_v4", 32'(y_b), 32'd0);
        wait_b(145); check("b_y_v5", 32'(y_b), 32'd1);
        wait_b(285); check("b_y_v10", 32'(y_b), 32'd2);
        wait_b(313); check("b_y_v11", 32'(y_b), 32'd3);
                     check("b_x_v11", 32'(x_b), 32'd4);
        wait_fs_b(532, "b_frame_start_1");
        wait_b(534); check("b_hsync_low_slots", 32'(hs_low_b), 32'd57);
                     check("b_vsync_low_slots", 32'(vs_low_b), 32'd56);
                     check("b_blank_high_slots", 32'(bl_high_b), 32'd280);
        wait_fs_b(1064, "b_frame_start_2");
        wait_b(1214);
        check("b_pre_reset_blank", 32'(bl_b), 32'd1);
        #3 rst_b = 1'b0;
        #1;
        check("b_rst_x", 32'(x_b), 32'd4);
        check("b_rst_y", 32'(y_b), 32'd3);
        check("b_rst_hs", 32'(hs_b), 32'd1);
        check("b_rst_vs", 32'(vs_b), 32'd1);
        check("b_rst_blank", 32'(bl_b), 32'd0);
        check("b_rst_rgb", 32'(rgb_b), 32'h000000);
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        wait_b(21);  check("b_restart_h19", 32'(bl_b), 32'd1);
        wait_b(22);  check("b_restart_h20", 32'(bl_b), 32'd0);
        wait_fs_b(532, "b_frame_start_after_rst");
        check("b_parked_outside", 32'(viol_b), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("a_rst_x", 32'(x_a), 32'd160);
        check("a_rst_y", 32'(y_a), 32'd144);
        check("a_rst_hs", 32'(hs_a), 32'd1);
        check("a_rst_vs", 32'(vs_a), 32'd1);
        check("a_rst_blank", 32'(bl_a), 32'd0);
        check("a_rst_rgb", 32'(rgb_a), 32'h000000);
        check("a_rst_fs", 32'(fs_a), 32'd0);
        check("b_rst0_x", 32'(x_b), 32'd4);
        rst_n = 1'b1;
        rst_b = 1'b1;
        fork
            seq_a();
            seq_b();
        join
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gb_vga_scanout.md
Name: gb_vga_scanout

Overview:
- Downstream consumer of the double-buffered frame buffer. Generates 640x480@60 VGA timing.
- Drives the frame buffer read coordinates (X_read/Y_read) to scale the 160x144 Game Boy image 3x into a centred 480x432 window.
- Converts the returned 2-bit shade to 24-bit RGB through a fixed palette.
- Aligns sync and blank with the RAM read latency.
- Parks the read coordinates out of range outside the window, so the frame buffer's vblank swap condition holds.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync lines
V_BP, 33, vertical back porch
SCALE, 3, integer upscale factor
X_OFF, 80, first window column
Y_OFF, 24, first window line
RD_LAT, 1, frame buffer read latency in pixel slots

Ports:
clock  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel-slot strobe (every 2nd clock)
fb_pixel  in  2  shade from frame buffer out
X_read  out  9  frame buffer read column
Y_read  out  9  frame buffer read row
hsync_n  out  1  VGA hsync, active low
vsync_n  out  1  VGA vsync, active low
blank_n  out  1  low outside the 640x480 active area
red  out  8  pixel red
green  out  8  pixel green
blue  out  8  pixel blue
frame_start  out  1  one-clock pulse when hc=0, vc=0 is entered

Behaviour:
- Reset and state advance:
  - Asynchronous reset, active low.
  - On reset: hc=0, vc=0, sub-counters=0, X_read=160, Y_read=144, hsync_n=1, vsync_n=1, blank_n=0, RGB=0, frame_start=0, delay pipeline cleared to blank/idle.
  - All state advances only on clock edges with pix_en=1.
  - With pix_en=0, every register holds, except frame_start, which is cleared.
- Counters:
  - hc counts 0..H_total-1, where H_total = sum of the H parameters (800).
  - vc increments when hc wraps. V_total is 525.
  - vc wraps to 0 after 524.
- Window:
  - win_x = X_OFF <= hc < X_OFF + SCALE*160.
  - win_y = Y_OFF <= vc < Y_OFF + SCALE*144.
- Coordinate generation uses counters only, no divider:
  - xsub counts 0..SCALE-1 inside win_x; gbx increments when xsub wraps.
  - Both reset to 0 at hc = X_OFF-1.
  - ysub/gby step once per line when the line is inside win_y.
  - ysub/gby reset at vc = Y_OFF-1 and at frame wrap.
- Registered read coordinates (update one pixel slot after the counters):
  - When win_x and win_y: X_read=gbx, Y_read=gby.
  - Otherwise: X_read=160, Y_read=144 (both out of range).
- Latency alignment:
  - Raw hsync, vsync, blank and window flags pass through a delay of 1+RD_LAT pixel slots.
  - fb_pixel is sampled RD_LAT slots after X_read/Y_read is presented.
  - Result: the RGB, sync and blank outputs all lag hc/vc by exactly 1+RD_LAT slots, uniformly.
- Sync timing:
  - hsync_n is low for hc in [656, 752).
  - vsync_n is low for vc in [490, 492).
  - blank_n is high for hc<640 and vc<480.
- Colour:
  - Inside the delayed window, RGB = PALETTE[fb_pixel].
  - Inside active area but outside the window: border colour BORDER_RGB.
  - When blank_n=0: RGB = 0.
- Widths and wrap: hc and vc are 10 bits. gbx never exceeds 159 and gby never exceeds 143. Both are guarded by the window, not by wrap.
- frame_start: asserted for one clock on the pix_en edge that moves the counters to (0,0).
- Reset mid-frame: immediate return to the reset values. First frame_start occurs at the first full wrap after release.

Decomposition:
- Package gb_video_pkg holds:
  - GB_W=160, GB_H=144.
  - shade_t (2-bit).
  - rgb_t (24-bit struct).
  - PALETTE[4]: 0=E0F8D0, 1=88C070, 2=346856, 3=081820.
  - BORDER_RGB=000000.
  - VGA default timing constants.
- One sub-module, vga_timing_gen: hc/vc counters plus raw sync and blank. The scaling, coordinate generation, delay line and palette stay in gb_vga_scanout.

Test Plan:
- Reset: hold reset_n=0 for 5 clocks, then release -> X_read=160, Y_read=144, hsync_n=1, blank_n=0. First frame_start arrives exactly 800*525 pix_en slots after release.
- Timing check over one frame -> hsync_n low for 96 slots per line, period 800. vsync_n low for 2 lines, period 525 lines. 480 lines with blank_n=1 runs of 640.
- Scaling: at vc=24, hc=80..82 -> X_read=0, Y_read=0. At hc=83 -> X_read=1. At hc=559 -> X_read=159. At hc=560 -> X_read=160. Lines vc=24..26 -> Y_read=0; vc=455 -> Y_read=143; vc=456 -> Y_read=144.
- Latency: model RAM returning fb_pixel=X_read[1:0] after RD_LAT -> at output column 80 (delayed), RGB=E0F8D0. Column 83 -> 88C070. Column 79 -> 000000. Repeat with RD_LAT=2.
- Swap window: across vc=456..524 and the horizontal blank of every line -> X_read>=160 or Y_read>=144 at all times.
- Reset mid-frame: assert reset_n=0 at vc=200, hc=300, with no clock edge -> outputs take reset values immediately. Counters restart from (0,0) after release.
